// File: rtl/squares_mem_mover.sv
// squares_mem_mover: Avalon-MM master running FILL / COPY / SUM commands on a single-port RAM.
// Latency: FILL 1 cycle/word, COPY 2+READ_LATENCY, SUM 1+READ_LATENCY; done one cycle after the last access.
// Backpressure: none on the bus (no waitrequest); start is ignored while busy.
// Ports: clk/reset_n; command port start, op, src_addr, dst_addr, length, fill_data, fill_be;
//        status busy, done, sum; memory master address, byteenable, chipselect, write,
//        writedata, clken, readdata.
module squares_mem_mover #(
    parameter int ADDR_W       = 8,
    parameter int DATA_W       = 32,
    parameter int READ_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [1:0]            op,
    input  logic [ADDR_W-1:0]     src_addr,
    input  logic [ADDR_W-1:0]     dst_addr,
    input  logic [ADDR_W:0]       length,
    input  logic [DATA_W-1:0]     fill_data,
    input  logic [DATA_W/8-1:0]   fill_be,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_W-1:0]     sum,
    output logic [ADDR_W-1:0]     address,
    output logic [DATA_W/8-1:0]   byteenable,
    output logic                  chipselect,
    output logic                  write,
    output logic [DATA_W-1:0]     writedata,
    output logic                  clken,
    input  logic [DATA_W-1:0]     readdata
);

    localparam int BE_W  = DATA_W / 8;
    localparam int LAT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

    localparam logic [1:0] OP_FILL = 2'b00;
    localparam logic [1:0] OP_COPY = 2'b01;
    localparam logic [1:0] OP_SUM  = 2'b10;
    localparam logic [1:0] OP_RSV  = 2'b11;

    localparam logic [BE_W-1:0]   BE_ALL   = '1;
    localparam logic [ADDR_W:0]   LEN_MAX  = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]   LEN_ONE  = (ADDR_W+1)'(1);
    localparam logic [LAT_W-1:0]  LAT_LAST = LAT_W'(READ_LATENCY - 1);

    typedef enum logic [2:0] {
        IDLE,
        FILL_WR,
        RD,
        LAT,
        WR,
        FIN
    } state_t;

    state_t             state;
    logic [1:0]         op_r;
    logic [ADDR_W-1:0]  src_r;
    logic [ADDR_W-1:0]  dst_r;
    logic [ADDR_W-1:0]  last_idx;   // index of the final word (length-1 after clamping)
    logic [ADDR_W-1:0]  idx;        // current word index i
    logic [LAT_W-1:0]   lat_cnt;
    logic [DATA_W-1:0]  acc;

    logic [ADDR_W:0]    len_eff;
    logic [ADDR_W-1:0]  idx_nx;
    logic [DATA_W-1:0]  acc_nx;
    logic               last_word;

    // Counts above the memory size collapse to one full pass over the RAM.
    assign len_eff   = (length > LEN_MAX) ? LEN_MAX : length;
    assign idx_nx    = idx + ADDR_W'(1);
    assign acc_nx    = acc + readdata;
    assign last_word = (idx == last_idx);
    assign clken     = 1'b1;

    // Bus outputs are registered together with the state, so the values driven
    // in a cycle are the ones belonging to the state occupied in that cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            op_r       <= 2'b00;
            src_r      <= '0;
            dst_r      <= '0;
            last_idx   <= '0;
            idx        <= '0;
            lat_cnt    <= '0;
            acc        <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            sum        <= '0;
            address    <= '0;
            byteenable <= '0;
            chipselect <= 1'b0;
            write      <= 1'b0;
            writedata  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    chipselect <= 1'b0;
                    write      <= 1'b0;
                    if (start) begin
                        op_r     <= op;
                        src_r    <= src_addr;
                        dst_r    <= dst_addr;
                        last_idx <= ADDR_W'(len_eff - LEN_ONE);
                        idx      <= '0;
                        acc      <= '0;
                        busy     <= 1'b1;
                        if (len_eff == '0 || op == OP_RSV) begin
                            state <= FIN;
                            done  <= 1'b1;
                            // An empty SUM still completes and reports the cleared accumulator.
                            if (op == OP_SUM) begin
                                sum <= '0;
                            end
                        end else if (op == OP_FILL) begin
                            state      <= FILL_WR;
                            chipselect <= 1'b1;
                            write      <= 1'b1;
                            address    <= dst_addr;
                            writedata  <= fill_data;
                            byteenable <= fill_be;
                        end else begin
                            state      <= RD;
                            chipselect <= 1'b1;
                            write      <= 1'b0;
                            address    <= src_addr;
                            byteenable <= BE_ALL;
                        end
                    end
                end

                FILL_WR: begin
                    if (last_word) begin
                        state      <= FIN;
                        done       <= 1'b1;
                        chipselect <= 1'b0;
                        write      <= 1'b0;
                    end else begin
                        idx     <= idx_nx;
                        address <= dst_r + idx_nx;
                    end
                end

                RD: begin
                    state      <= LAT;
                    chipselect <= 1'b0;
                    write      <= 1'b0;
                    lat_cnt    <= '0;
                end

                LAT: begin
                    if (lat_cnt == LAT_LAST) begin
                        if (op_r == OP_COPY) begin
                            // writedata doubles as the capture buffer for the word in flight.
                            state      <= WR;
                            chipselect <= 1'b1;
                            write      <= 1'b1;
                            address    <= dst_r + idx;
                            writedata  <= readdata;
                            byteenable <= BE_ALL;
                        end else begin
                            acc <= acc_nx;
                            if (last_word) begin
                                state <= FIN;
                                done  <= 1'b1;
                                sum   <= acc_nx;
                            end else begin
                                idx        <= idx_nx;
                                state      <= RD;
                                chipselect <= 1'b1;
                                write      <= 1'b0;
                                address    <= src_r + idx_nx;
                                byteenable <= BE_ALL;
                            end
                        end
                    end else begin
                        lat_cnt <= lat_cnt + LAT_W'(1);
                    end
                end

                WR: begin
                    if (last_word) begin
                        state      <= FIN;
                        done       <= 1'b1;
                        chipselect <= 1'b0;
                        write      <= 1'b0;
                    end else begin
                        idx        <= idx_nx;
                        state      <= RD;
                        chipselect <= 1'b1;
                        write      <= 1'b0;
                        address    <= src_r + idx_nx;
                        byteenable <= BE_ALL;
                    end
                end

                FIN: begin
                    busy       <= 1'b0;
                    chipselect <= 1'b0;
                    write      <= 1'b0;
                    state      <= IDLE;
                end

                default: begin
                    state      <= IDLE;
                    busy       <= 1'b0;
                    chipselect <= 1'b0;
                    write      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_squares_mem_mover.sv
// tb_squares_mem_mover: drives squares_mem_mover against behavioural RAM slaves and a
// transaction-level model that lists, per command, the bus cycle expected in each busy cycle.
module tb_squares_mem_mover;

    localparam int RL1 = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n, start, start2;
    logic [1:0]  op;
    logic [7:0]  src_addr, dst_addr;
    logic [8:0]  length;
    logic [31:0] fill_data;
    logic [3:0]  fill_be;

    logic        busy, done, chipselect, write, clken;
    logic [31:0] sum, writedata, readdata;
    logic [7:0]  address;
    logic [3:0]  byteenable;

    logic        busy2, done2, chipselect2, write2, clken2;
    logic [31:0] sum2, writedata2, readdata2;
    logic [7:0]  address2;
    logic [3:0]  byteenable2;

    squares_mem_mover #(.ADDR_W(8), .DATA_W(32), .READ_LATENCY(RL1)) u_dut (
        .clk(clk), .reset_n(reset_n), .start(start), .op(op),
        .src_addr(src_addr), .dst_addr(dst_addr), .length(length),
        .fill_data(fill_data), .fill_be(fill_be),
        .busy(busy), .done(done), .sum(sum),
        .address(address), .byteenable(byteenable), .chipselect(chipselect),
        .write(write), .writedata(writedata), .clken(clken), .readdata(readdata)
    );

    squares_mem_mover #(.ADDR_W(8), .DATA_W(32), .READ_LATENCY(2)) u_dut2 (
        .clk(clk), .reset_n(reset_n), .start(start2), .op(op),
        .src_addr(src_addr), .dst_addr(dst_addr), .length(length),
        .fill_data(fill_data), .fill_be(fill_be),
        .busy(busy2), .done(done2), .sum(sum2),
        .address(address2), .byteenable(byteenable2), .chipselect(chipselect2),
        .write(write2), .writedata(writedata2), .clken(clken2), .readdata(readdata2)
    );

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    // RAM slave, 1-cycle read latency.
    logic [31:0] mem [256];
    logic [31:0] rd1;
    always @(posedge clk) begin
        if (chipselect && write) mem[address] = merge(mem[address], writedata, byteenable);
        if (chipselect && !write) rd1 <= mem[address];
    end
    assign readdata = rd1;

    // RAM slave, 2-cycle read latency.
    logic [31:0] mem2 [256];
    logic [31:0] p1, p2;
    always @(posedge clk) begin
        if (chipselect2 && write2) mem2[address2] = merge(mem2[address2], writedata2, byteenable2);
        if (chipselect2 && !write2) p1 <= mem2[address2];
        p2 <= p1;
    end
    assign readdata2 = p2;

    // Expected bus/status picture for one busy cycle.
    typedef struct packed {
        logic        busy;
        logic        done;
        logic        cs;
        logic        wr;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic        ld_sum;
        logic [31:0] sum;
    } exp_t;

    exp_t        q[$];
    logic [31:0] ref_mem [256];
    logic [31:0] exp_sum = '0;
    int          checks = 0, errors = 0;
    int          busy_cnt = 0, done_cnt = 0, cs_cnt = 0, built = 0, cyc = 0;
    bit          chk_en = 1'b0, in_reset = 1'b0;

    function automatic exp_t mk(input logic b, input logic dn, input logic c, input logic w,
                                input logic [7:0] a, input logic [31:0] wd, input logic [3:0] be,
                                input logic ls, input logic [31:0] s);
        exp_t e;
        e.busy = b; e.done = dn; e.cs = c; e.wr = w; e.addr = a;
        e.wdata = wd; e.be = be; e.ld_sum = ls; e.sum = s;
        return e;
    endfunction

    // Model: walks the command word by word on a scratch copy of memory, so overlapping
    // copies see their own earlier writes exactly as the ascending-order rule implies.
    task automatic build(input logic [1:0] o, input logic [7:0] s, input logic [7:0] d,
                         input logic [8:0] len, input logic [31:0] fd, input logic [3:0] fbe);
        logic [31:0] sm [256];
        logic [31:0] acc, v;
        int n;
        sm  = ref_mem;
        n   = (len > 9'd256) ? 256 : int'(len);
        acc = '0;
        if (o != 2'b11) begin
            for (int k = 0; k < n; k++) begin
                if (o == 2'b00) begin
                    q.push_back(mk(1, 0, 1, 1, 8'(d + k), fd, fbe, 0, 0));
                end else begin
                    q.push_back(mk(1, 0, 1, 0, 8'(s + k), 0, 4'hF, 0, 0));
                    v = sm[8'(s + k)];
                    for (int l = 0; l < RL1; l++) q.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
                    if (o == 2'b01) begin
                        q.push_back(mk(1, 0, 1, 1, 8'(d + k), v, 4'hF, 0, 0));
                        sm[8'(d + k)] = v;
                    end else begin
                        acc = acc + v;
                    end
                end
            end
        end
        q.push_back(mk(1, 1, 0, 0, 0, 0, 0, (o == 2'b10), acc));
    endtask

    // Compare process: one check per cycle while the bench is out of reset.
    always @(negedge clk) begin
        exp_t e;
        bit   bad;
        if (chk_en && reset_n && !in_reset) begin
            cyc++;
            if (q.size() > 0) e = q.pop_front();
            else              e = '0;
            if (e.cs && e.wr) ref_mem[e.addr] = merge(ref_mem[e.addr], e.wdata, e.be);
            if (e.ld_sum) exp_sum = e.sum;
            if (busy) busy_cnt++;
            if (done) done_cnt++;
            if (chipselect) cs_cnt++;
            bad = (busy !== e.busy) || (done !== e.done) || (chipselect !== e.cs) ||
                  (write !== e.wr) || (clken !== 1'b1) || (sum !== exp_sum);
            if (e.cs) bad = bad || (address !== e.addr) || (byteenable !== e.be);
            if (e.cs && e.wr) bad = bad || (writedata !== e.wdata);
            checks++;
            if (bad) begin
                errors++;
                $display("FAIL cycle %0d: got busy=%b done=%b cs=%b wr=%b addr=%h be=%h wd=%h sum=%h; expected busy=%b done=%b cs=%b wr=%b addr=%h be=%h wd=%h sum=%h",
                         cyc, busy, done, chipselect, write, address, byteenable, writedata, sum,
                         e.busy, e.done, e.cs, e.wr, e.addr, e.be, e.wdata, exp_sum);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    task automatic chk_mem(input string name);
        int nbad, first;
        nbad = 0; first = 0;
        for (int i = 0; i < 256; i++) begin
            if (mem[i] !== ref_mem[i]) begin
                if (nbad == 0) first = i;
                nbad++;
            end
        end
        checks++;
        if (nbad != 0) begin
            errors++;
            $display("FAIL %s: %0d words differ, first at %h got %h expected %h",
                     name, nbad, first[7:0], mem[first], ref_mem[first]);
        end
    endtask

    task automatic preload(input logic [7:0] a, input logic [31:0] v);
        mem[a]     = v;
        ref_mem[a] = v;
    endtask

    task automatic launch(input logic [1:0] o, input logic [7:0] s, input logic [7:0] d,
                          input logic [8:0] len, input logic [31:0] fd, input logic [3:0] fbe);
        @(posedge clk); #1;
        op = o; src_addr = s; dst_addr = d; length = len; fill_data = fd; fill_be = fbe;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        build(o, s, d, len, fd, fbe);
        built    = q.size();
        busy_cnt = 0; done_cnt = 0; cs_cnt = 0;
    endtask

    // Waits for the expected trace to drain; with noisy set, scrambles the command inputs
    // and throws extra start pulses while the command is still running.
    task automatic wait_done(input bit noisy);
        int c;
        c = 0;
        while (q.size() > 0 && c < 3000) begin
            if (noisy) begin
                op = 2'($urandom); src_addr = 8'($urandom); dst_addr = 8'($urandom);
                length = 9'($urandom); fill_data = $urandom; fill_be = 4'($urandom);
                start = (q.size() >= 2) && ($urandom_range(0, 2) == 0);
            end
            @(posedge clk); #1;
            start = 1'b0;
            c++;
        end
        start = 1'b0;
        checks++;
        if (q.size() > 0) begin
            errors++;
            $display("FAIL timeout: %0d expected cycles left unconsumed", q.size());
            q.delete();
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [1:0] o;
        logic [8:0] len;
        int         r, b2, d2, c2;

        reset_n = 1'b0; start = 1'b0; start2 = 1'b0;
        op = 2'b00; src_addr = '0; dst_addr = '0; length = '0; fill_data = '0; fill_be = '0;
        for (int i = 0; i < 256; i++) begin
            mem[i]     = $urandom;
            ref_mem[i] = mem[i];
            mem2[i]    = $urandom;
        end
        #2;
        chk("reset_outputs", {busy, done, chipselect, write, address, byteenable, clken},
            {1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 4'h0, 1'b1});
        chk("reset_wdata", writedata, 32'h0);
        chk("reset_sum", sum, 32'h0);
        chk("reset_dut2", {busy2, done2, chipselect2, write2, sum2[0], clken2}, 6'b000001);
        @(posedge clk); #1;
        reset_n = 1'b1;
        chk_en  = 1'b1;

        // FILL 4 words at 0x10.
        launch(2'b00, 8'h00, 8'h10, 9'd4, 32'hA5A5A5A5, 4'hF);
        chk("fill_model_len", built, 5);
        wait_done(1);
        chk("fill_busy_cycles", busy_cnt, 5);
        chk("fill_done_pulses", done_cnt, 1);
        chk("fill_readback", mem[8'h13], 32'hA5A5A5A5);
        chk_mem("fill_mem");

        // SUM over 1, 2, 3, 0xFFFFFFFF wraps to 5.
        preload(8'h00, 32'h1); preload(8'h01, 32'h2);
        preload(8'h02, 32'h3); preload(8'h03, 32'hFFFFFFFF);
        launch(2'b10, 8'h00, 8'h00, 9'd4, 32'h0, 4'h0);
        chk("sum_model_len", built, 9);
        wait_done(1);
        chk("sum_busy_cycles", busy_cnt, 9);
        chk("sum_done_pulses", done_cnt, 1);
        chk("sum_value", sum, 32'h5);

        // COPY across the top of memory.
        preload(8'hFE, 32'hCAFE00FE); preload(8'hFF, 32'hCAFE00FF);
        launch(2'b01, 8'hFE, 8'h40, 9'd4, 32'h0, 4'h0);
        chk("copy_model_len", built, 13);
        wait_done(1);
        chk("copy_busy_cycles", busy_cnt, 13);
        chk("copy_wrap_first", mem[8'h40], 32'hCAFE00FE);
        chk("copy_wrap_last", mem[8'h43], 32'h2);
        chk_mem("copy_mem");

        // Empty and reserved commands, each with a start pulse during the done cycle.
        launch(2'b00, 8'h00, 8'h20, 9'd0, 32'h12345678, 4'hF);
        start = 1'b1; op = 2'b00; length = 9'd3;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(0);
        chk("len0_busy_cycles", busy_cnt, 1);
        chk("len0_no_cs", cs_cnt, 0);
        launch(2'b11, 8'h05, 8'h20, 9'd5, 32'h12345678, 4'hF);
        start = 1'b1; op = 2'b01; length = 9'd3;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(0);
        chk("rsv_busy_cycles", busy_cnt, 1);
        chk("rsv_no_cs", cs_cnt, 0);
        chk_mem("empty_mem");

        // Overlapping forward copy smears the first word.
        preload(8'h60, 32'h600D0001);
        launch(2'b01, 8'h60, 8'h61, 9'd4, 32'h0, 4'h0);
        wait_done(1);
        chk("overlap_smear", mem[8'h64], 32'h600D0001);
        chk_mem("overlap_mem");

        // Reset in the middle of a COPY, after two words have been written.
        launch(2'b01, 8'h30, 8'h50, 9'd4, 32'h0, 4'h0);
        for (int c = 0; c < 100 && q.size() > 7; c++) begin
            @(posedge clk); #1;
        end
        in_reset = 1'b1;
        q.delete();
        exp_sum  = '0;
        reset_n  = 1'b0;
        #1;
        chk("abort_outputs", {busy, done, chipselect, write, address, byteenable},
            {1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 4'h0});
        chk("abort_wdata_sum", writedata | sum, 32'h0);
        chk("abort_no_done", done_cnt, 0);
        repeat (2) @(posedge clk);
        #1;
        reset_n  = 1'b1;
        in_reset = 1'b0;
        chk_mem("abort_mem");
        launch(2'b00, 8'h00, 8'h70, 9'd3, 32'h0BADF00D, 4'h5);
        wait_done(1);
        chk("post_abort_done", done_cnt, 1);
        chk_mem("post_abort_mem");

        // Randomised commands.
        for (int t = 0; t < 40; t++) begin
            o = 2'($urandom_range(0, 3));
            r = $urandom_range(0, 9);
            if (r < 7)       len = 9'($urandom_range(1, 12));
            else if (r == 7) len = 9'd0;
            else if (r == 8) len = 9'd256;
            else             len = 9'($urandom_range(257, 511));
            launch(o, 8'($urandom), 8'($urandom), len, $urandom, 4'($urandom));
            wait_done(1);
            chk_mem("rand_mem");
        end

        // Two-cycle read latency build: COPY of two words.
        mem2[8'h20] = 32'h11112222;
        mem2[8'h21] = 32'h33334444;
        @(posedge clk); #1;
        op = 2'b01; src_addr = 8'h20; dst_addr = 8'h80; length = 9'd2; start2 = 1'b1;
        @(posedge clk); #1;
        start2 = 1'b0;
        b2 = 0; d2 = 0; c2 = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (busy2) b2++;
            if (done2) d2++;
            if (chipselect2) c2++;
        end
        chk("rl2_busy_cycles", b2, 9);
        chk("rl2_done_pulses", d2, 1);
        chk("rl2_accesses", c2, 4);
        chk("rl2_word0", mem2[8'h80], 32'h11112222);
        chk("rl2_word1", mem2[8'h81], 32'h33334444);

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/squares_mem_mover.md
Name: squares_mem_mover

Overview:
- Avalon-MM master that drives the 256 x 32 single-port on-chip RAM slave in the Squares system.
- Executes one command at a time:
  - FILL: write a constant to a region.
  - COPY: move a region from one address to another.
  - SUM: add up the words in a region.
- Controlled by a start/busy/done command port from the control logic.

Parameters:
- ADDR_W, 8, word-address width; the memory holds 2^ADDR_W words.
- DATA_W, 32, data width; byteenable width is DATA_W/8.
- READ_LATENCY, 1, cycles from the read-address cycle until readdata is valid (minimum 1).

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle command strobe; sampled only in IDLE
- op  in  2  command: 00 FILL, 01 COPY, 10 SUM, 11 reserved (completes with no accesses)
- src_addr  in  ADDR_W  source base address (COPY, SUM)
- dst_addr  in  ADDR_W  destination base address (FILL, COPY)
- length  in  ADDR_W+1  word count, 0..256
- fill_data  in  DATA_W  FILL write value
- fill_be  in  DATA_W/8  FILL byteenable
- busy  out  1  command in progress
- done  out  1  one-cycle completion pulse
- sum  out  DATA_W  SUM result, modulo 2^DATA_W
- address  out  ADDR_W  memory word address
- byteenable  out  DATA_W/8  memory byteenable
- chipselect  out  1  memory access strobe
- write  out  1  write qualifier
- writedata  out  DATA_W  write data
- clken  out  1  memory clock enable
- readdata  in  DATA_W  memory read data

Behaviour:
- Reset values:
  - reset_n low asynchronously forces IDLE.
  - busy=0, done=0, chipselect=0, write=0.
  - address=0, byteenable=0, writedata=0, sum=0.
  - Internal index and capture registers cleared.
- clken: tied to 1 at all times.
- Bus protocol:
  - All bus outputs are registered.
  - No waitrequest: each cycle with chipselect=1 is one accepted access.
  - write=1 is allowed only together with chipselect=1.
  - During reads: write=0 and byteenable=all ones.
  - When idle: chipselect=0 and write=0.
- Command latch:
  - start in IDLE latches op, src_addr, dst_addr, length, fill_data and fill_be.
  - Clears index i to 0.
  - busy=1 from the next cycle through the cycle in which done=1, inclusive.
  - start while busy is ignored.
- States: IDLE, FILL_WR, RD, LAT, WR, FIN.
- IDLE: start -> FIN if length==0 or op==11; otherwise FILL_WR (FILL) or RD (COPY, SUM).
- FILL_WR:
  - Drives chipselect=1, write=1, address=dst+i, writedata=fill_data, byteenable=fill_be.
  - i increments; after word length-1 -> FIN.
  - Throughput 1 word per cycle.
- RD: drives chipselect=1, write=0, address=src+i, then -> LAT.
- LAT:
  - Lasts READ_LATENCY cycles with chipselect=0.
  - At the end of the last LAT cycle, readdata is captured.
  - COPY: capture into the write buffer, -> WR.
  - SUM: add to the accumulator, i++, then -> RD, or -> FIN if i was length-1.
- WR:
  - Drives chipselect=1, write=1, address=dst+i, writedata=captured word, byteenable=all ones.
  - i++, then -> RD, or -> FIN after the last word.
- Cycles per word: COPY 2+READ_LATENCY; SUM 1+READ_LATENCY.
- FIN:
  - done=1 for one cycle.
  - For SUM, sum is loaded from the accumulator; sum holds its value until the next SUM completes.
  - -> IDLE, where start is accepted again.
- Address arithmetic: src+i and dst+i wrap modulo 2^ADDR_W.
- length: 256 covers the whole memory.
- length > 256: clamped to 256.
- Overlapping COPY:
  - Each word is read before it is written, in ascending order.
  - With dst > src and overlap, data smears forward. This is documented behaviour, not corrected.
- SUM accumulator: cleared on start; overflow discarded.
- reset_n mid-command: abort immediately and leave memory partially written. No done pulse.

Test Plan:
- FILL dst=0x10, length=4, fill_data=0xA5A5A5A5, fill_be=0xF -> 4 consecutive write cycles to 0x10..0x13; done 1 cycle later; busy high for 5 cycles; readback matches.
- Preload 0x00..0x03 with 1, 2, 3, 0xFFFFFFFF; SUM src=0, length=4 -> 8 bus cycles; sum=0x00000005; done pulses once.
- COPY src=0xFE, dst=0x40, length=4 -> reads 0xFE, 0xFF, 0x00, 0x01 (wrap); writes to 0x40..0x43 hold those words; 12 cycles of busy before the done cycle.
- length=0 with any op, and op=11 -> no chipselect; done the cycle after next; second start pulsed during busy is ignored.
- Reset mid-COPY: assert reset_n low after 2 words -> all outputs 0 within the same cycle; no done; a new FILL afterwards completes normally.
- READ_LATENCY=2 build, COPY length=2 -> 4 cycles per word; data captured correctly (model memory with a 2-cycle read).
